riscv_instr_mem_responder: RTL and testbench

// - Responder (memory) end of the core's instruction fetch interface (req/addr/gnt/rvalid/rdata/err).
// - Word-wide instruction RAM that grants requests, returns data after a fixed latency, and flags
//   out-of-range fetches on err (which drives the core's instr_err_pmp_i).
// - Used as TCM in small configs and as the fetch-side model in core-level benches; side port preloads images.

---
 rtl/riscv_instr_mem_responder.sv | 116 +++++++++++
 tb/tb_riscv_instr_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch responder: word RAM with fixed-latency responses, range error and preload port.
// Optional grant/error statistics counters are built when IMEM_RESP_STATS_EN is defined.
module riscv_instr_mem_responder #(
   parameter int unsigned ADDR_WIDTH      = 12,
   parameter logic [31:0] BASE_ADDR       = 32'h1C00_8000,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_req_i,
   input  logic [31:0]           instr_addr_i,
   output logic                  instr_gnt_o,
   output logic                  instr_rvalid_o,
   output logic [31:0]           instr_rdata_o,
   output logic                  instr_err_o,
   input  logic                  gnt_stall_i,
   input  logic                  load_we_i,
   input  logic [ADDR_WIDTH-1:0] load_addr_i,
   input  logic [31:0]           load_wdata_i,
   output logic [31:0]           stat_gnt_cnt_o,
   output logic [31:0]           stat_err_cnt_o
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [31:0]        mem [DEPTH];
   logic [2:0]         outstanding;
   logic [31:0]        offset;
   logic [31:0]        word_idx;
   logic               in_range;
   logic [LATENCY-1:0] pipe_vld;
   logic [LATENCY-1:0] pipe_err;
   logic [31:0]        pipe_data [LATENCY];

   // Addresses below BASE_ADDR wrap to a huge index and fall out of range.
   assign offset   = instr_addr_i - BASE_ADDR;
   assign word_idx = offset >> 2;
   assign in_range = (word_idx >> ADDR_WIDTH) == 32'd0;

   // A response leaving this cycle frees a slot, so a full pipe can still accept.
   assign instr_gnt_o = instr_req_i & ~gnt_stall_i &
                        ((outstanding < 3'(MAX_OUTSTANDING)) | instr_rvalid_o);

   assign instr_rvalid_o = pipe_vld[LATENCY-1];
   assign instr_err_o    = pipe_err[LATENCY-1];
   assign instr_rdata_o  = pipe_data[LATENCY-1];

   always_ff @(posedge clk) begin
      if (load_we_i) begin
         mem[load_addr_i] <= load_wdata_i;
      end
   end

   // Stages only load on a valid entry, so the last stage holds its data between responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         pipe_err <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_data[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= instr_gnt_o;
         if (instr_gnt_o) begin
            pipe_data[0] <= in_range ? mem[word_idx[ADDR_WIDTH-1:0]] : 32'h0;
            pipe_err[0]  <= ~in_range;
         end
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) begin
               pipe_data[i] <= pipe_data[i-1];
               pipe_err[i]  <= pipe_err[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outstanding <= '0;
      end else begin
         case ({instr_gnt_o, instr_rvalid_o})
            2'b10:   outstanding <= outstanding + 3'd1;
            2'b01:   outstanding <= outstanding - 3'd1;
            default: outstanding <= outstanding;
         endcase
      end
   end

`ifdef IMEM_RESP_STATS_EN
   logic [31:0] gnt_cnt;
   logic [31:0] err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_cnt <= '0;
         err_cnt <= '0;
      end else begin
         if (instr_gnt_o) begin
            gnt_cnt <= gnt_cnt + 32'd1;
         end
         if (instr_rvalid_o && instr_err_o) begin
            err_cnt <= err_cnt + 32'd1;
         end
      end
   end

   assign stat_gnt_cnt_o = gnt_cnt;
   assign stat_err_cnt_o = err_cnt;
`else
   assign stat_gnt_cnt_o = 32'h0;
   assign stat_err_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Bench for riscv_instr_mem_responder: unit 0 at LATENCY=1, unit 1 at LATENCY=3, both MAX_OUTSTANDING=2.
module tb_riscv_instr_mem_responder;

   localparam logic [31:0] BASE = 32'h1C00_8000;
   localparam int          MAXO = 2;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req [2];
   logic [31:0] addr [2];
   logic        stall [2];
   logic        lwe [2];
   logic [11:0] laddr [2];
   logic [31:0] lwdata [2];
   logic        gnt [2];
   logic        rvalid [2];
   logic [31:0] rdata [2];
   logic        err [2];
   logic [31:0] sgnt [2];
   logic [31:0] serr [2];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] shadow [2][4096];
   resp_t       rq [2][$];
   logic [31:0] last_d [2];
   logic        last_e [2];
   int          gcnt [2];
   int          ecnt [2];
   logic [31:0] got_d [2][$];
   logic        got_e [2][$];
   int          rv_cyc [2][$];
   logic        gh [2][$];

   always #5 clk = ~clk;

   riscv_instr_mem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(BASE), .LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
      .clk(clk), .rst(rst), .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
      .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
      .gnt_stall_i(stall[0]), .load_we_i(lwe[0]), .load_addr_i(laddr[0]), .load_wdata_i(lwdata[0]),
      .stat_gnt_cnt_o(sgnt[0]), .stat_err_cnt_o(serr[0]));

   riscv_instr_mem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(BASE), .LATENCY(3), .MAX_OUTSTANDING(2)) u1 (
      .clk(clk), .rst(rst), .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
      .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
      .gnt_stall_i(stall[1]), .load_we_i(lwe[1]), .load_addr_i(laddr[1]), .load_wdata_i(lwdata[1]),
      .stat_gnt_cnt_o(sgnt[1]), .stat_err_cnt_o(serr[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Shadow memory follows the preload port at the same edge as the DUT array.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int u = 0; u < 2; u++) begin
         if (lwe[u]) shadow[u][laddr[u]] <= lwdata[u];
      end
   end

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         int          lat;
         logic        due_now;
         logic        exp_gnt;
         logic [31:0] off;
         resp_t       r;
         lat = (u == 0) ? 1 : 3;
         if (rst) begin
            rq[u].delete();
            last_d[u] = 32'h0;
            last_e[u] = 1'b0;
            gcnt[u]   = 0;
            ecnt[u]   = 0;
            chk($sformatf("rst_rvalid%0d", u), {31'h0, rvalid[u]}, 32'h0);
            chk($sformatf("rst_rdata%0d", u), rdata[u], 32'h0);
         end else begin
            if (rvalid[u]) begin
               got_d[u].push_back(rdata[u]);
               got_e[u].push_back(err[u]);
               rv_cyc[u].push_back(cyc);
            end
            if (req[u]) gh[u].push_back(gnt[u]);
`ifdef IMEM_RESP_STATS_EN
            chk($sformatf("stat_gnt%0d", u), sgnt[u], 32'(gcnt[u]));
            chk($sformatf("stat_err%0d", u), serr[u], 32'(ecnt[u]));
`else
            chk($sformatf("stat_gnt%0d", u), sgnt[u], 32'h0);
            chk($sformatf("stat_err%0d", u), serr[u], 32'h0);
`endif
            due_now = (rq[u].size() > 0) && (rq[u][0].due == cyc);
            exp_gnt = req[u] && !stall[u] && ((rq[u].size() < MAXO) || due_now);
            chk($sformatf("gnt%0d", u), {31'h0, gnt[u]}, {31'h0, exp_gnt});
            chk($sformatf("rvalid%0d", u), {31'h0, rvalid[u]}, {31'h0, due_now});
            if (due_now) begin
               r = rq[u].pop_front();
               last_d[u] = r.data;
               last_e[u] = r.err;
               if (r.err) ecnt[u]++;
            end
            chk($sformatf("rdata%0d", u), rdata[u], last_d[u]);
            chk($sformatf("err%0d", u), {31'h0, err[u]}, {31'h0, last_e[u]});
            if (exp_gnt) begin
               gcnt[u]++;
               off = addr[u] - BASE;
               r.due = cyc + lat;
               if ((off >> 2) < 32'd4096) begin
                  r.data = shadow[u][off[13:2]];
                  r.err  = 1'b0;
               end else begin
                  r.data = 32'h0;
                  r.err  = 1'b1;
               end
               rq[u].push_back(r);
            end
         end
      end
   end

   initial begin
      int st;
      for (int u = 0; u < 2; u++) begin
         req[u] = 0; addr[u] = BASE; stall[u] = 0; lwe[u] = 0; laddr[u] = '0; lwdata[u] = '0;
         for (int i = 0; i < 4096; i++) shadow[u][i] = 32'h0;
      end
      repeat (3) step();
      rst = 1'b0;

      // Preload words 0..3 with 0x13+i and word 5 with 0x55 in both units.
      for (int i = 0; i < 5; i++) begin
         for (int u = 0; u < 2; u++) begin
            lwe[u] = 1; laddr[u] = (i == 4) ? 12'd5 : 12'(i); lwdata[u] = (i == 4) ? 32'h55 : 32'h13 + 32'(i);
         end
         step();
      end
      lwe[0] = 0; lwe[1] = 0;
      step();

      // Back-to-back fetches at LATENCY=1.
      got_d[0].delete(); got_e[0].delete(); rv_cyc[0].delete();
      st = cyc;
      for (int i = 0; i < 4; i++) begin
         req[0] = 1; addr[0] = BASE + 32'(4 * i);
         step();
      end
      req[0] = 0;
      repeat (3) step();
      chk("t1_count", 32'(got_d[0].size()), 32'd4);
      chk("t1_d0", got_d[0][0], 32'h13);
      chk("t1_d1", got_d[0][1], 32'h14);
      chk("t1_d2", got_d[0][2], 32'h15);
      chk("t1_d3", got_d[0][3], 32'h16);
      chk("t1_first_cyc", 32'(rv_cyc[0][0]), 32'(st + 1));
      chk("t1_last_cyc", 32'(rv_cyc[0][3]), 32'(st + 4));

      // LATENCY=3 with two outstanding: grant pattern 1,1,0 repeating.
      gh[1].delete();
      req[1] = 1; addr[1] = BASE;
      repeat (9) step();
      req[1] = 0;
      repeat (5) step();
      chk("t2_len", 32'(gh[1].size()), 32'd9);
      for (int i = 0; i < 9; i++)
         chk($sformatf("t2_gnt%0d", i), {31'h0, gh[1][i]}, (i % 3 == 2) ? 32'h0 : 32'h1);

      // Out-of-range below and above, plus unaligned in-range address.
      got_d[0].delete(); got_e[0].delete();
      req[0] = 1; addr[0] = 32'h1C00_7FFC; step();
      addr[0] = 32'h1C00_C000; step();
      addr[0] = 32'h1C00_8002; step();
      req[0] = 0;
      repeat (3) step();
      chk("t3_count", 32'(got_d[0].size()), 32'd3);
      chk("t3_lo_err", {31'h0, got_e[0][0]}, 32'h1);
      chk("t3_lo_data", got_d[0][0], 32'h0);
      chk("t3_hi_err", {31'h0, got_e[0][1]}, 32'h1);
      chk("t3_hi_data", got_d[0][1], 32'h0);
      chk("t3_unal_err", {31'h0, got_e[0][2]}, 32'h0);
      chk("t3_unal_data", got_d[0][2], 32'h13);

      // Wait-state injection for three cycles.
      got_d[0].delete(); got_e[0].delete(); gh[0].delete();
      req[0] = 1; addr[0] = BASE + 32'd4; stall[0] = 1;
      repeat (3) step();
      stall[0] = 0;
      step();
      req[0] = 0;
      repeat (3) step();
      chk("t4_len", 32'(gh[0].size()), 32'd4);
      chk("t4_g0", {31'h0, gh[0][0]}, 32'h0);
      chk("t4_g2", {31'h0, gh[0][2]}, 32'h0);
      chk("t4_g3", {31'h0, gh[0][3]}, 32'h1);
      chk("t4_count", 32'(got_d[0].size()), 32'd1);
      chk("t4_data", got_d[0][0], 32'h14);

      // Reset with two requests in flight at LATENCY=3.
      req[1] = 1; addr[1] = BASE + 32'd8;
      repeat (2) step();
      req[1] = 0;
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      got_d[1].delete(); got_e[1].delete();
      repeat (6) step();
      chk("t5_no_rvalid", 32'(got_d[1].size()), 32'd0);
      chk("t5_stat_gnt", sgnt[1], 32'h0);
      req[1] = 1; addr[1] = BASE + 32'd8; step();
      req[1] = 0;
      repeat (4) step();
      chk("t5_recover_cnt", 32'(got_d[1].size()), 32'd1);
      chk("t5_recover_data", got_d[1][0], 32'h15);

      // Same-cycle preload and fetch of word 5 returns the old word.
      got_d[0].delete(); got_e[0].delete();
      req[0] = 1; addr[0] = BASE + 32'd20; lwe[0] = 1; laddr[0] = 12'd5; lwdata[0] = 32'hDEADBEEF;
      step();
      lwe[0] = 0;
      step();
      req[0] = 0;
      repeat (3) step();
      chk("t6_count", 32'(got_d[0].size()), 32'd2);
      chk("t6_old", got_d[0][0], 32'h55);
      chk("t6_new", got_d[0][1], 32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
